// File: rtl/car_step_sequencer_if.sv
// Evaluator handshake and car-state bundle for car_step_sequencer.
// The score field and its modport entries exist only when CAR_SCORE_EN is defined.
interface car_step_sequencer_if;
    logic        enable;
    logic [1:0]  move_result;
    logic        step;
    logic [5:0]  position;
    logic [1:0]  lives;
    logic        hit;
    logic        row_advance;
    logic        game_over;
`ifdef CAR_SCORE_EN
    logic [15:0] score;

    modport master (
        input  enable, move_result,
        output step, position, lives, hit, row_advance, game_over, score
    );
    modport slave (
        output enable, move_result,
        input  step, position, lives, hit, row_advance, game_over, score
    );
`else
    modport master (
        input  enable, move_result,
        output step, position, lives, hit, row_advance, game_over
    );
    modport slave (
        output enable, move_result,
        input  step, position, lives, hit, row_advance, game_over
    );
`endif
endinterface

// File: rtl/car_step_sequencer.sv
// Game-step pacer and sole owner of the car's lane and lives for Car Dash V2.
// Define CAR_SCORE_EN to add the saturating 16-bit steps-survived score.
module car_step_sequencer #(
    parameter int STEP_DIV    = 50_000_000,
    parameter int RESULT_LAT  = 2,
    parameter int START_POS   = 2,
    parameter int START_LIVES = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    car_step_sequencer_if.master bus
);

    localparam int CW = $clog2(STEP_DIV);
    localparam int LW = $clog2(RESULT_LAT + 2);

    // The strobe is registered, so the decision is taken one enabled cycle
    // early; the strobe cycle itself is the first WAIT cycle.
    localparam logic [CW-1:0] STEP_LAST = CW'(STEP_DIV - 2);
    localparam logic [LW-1:0] LAT_LAST  = LW'(RESULT_LAT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_WAIT,
        S_APPLY,
        S_OVER
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [LW-1:0] lat;
    logic [1:0]    result_q;
    logic          step_q;
    logic          hit_q;
    logic          adv_q;
    logic          over_q;
    logic [5:0]    pos_q;
    logic [1:0]    lives_q;
`ifdef CAR_SCORE_EN
    logic [15:0]   score_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            count    <= '0;
            lat      <= '0;
            result_q <= '0;
            step_q   <= 1'b0;
            hit_q    <= 1'b0;
            adv_q    <= 1'b0;
            over_q   <= 1'b0;
            pos_q    <= 6'(START_POS);
            lives_q  <= 2'(START_LIVES);
`ifdef CAR_SCORE_EN
            score_q  <= '0;
`endif
        end else begin
            step_q <= 1'b0;
            hit_q  <= 1'b0;
            adv_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.enable) begin
                        state <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (bus.enable) begin
                        if (count == STEP_LAST) begin
                            count  <= '0;
                            lat    <= '0;
                            step_q <= 1'b1;
                            state  <= S_WAIT;
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                end
                // Runs regardless of enable so an issued step always lands.
                S_WAIT: begin
                    if (lat == LAT_LAST) begin
                        result_q <= bus.move_result;
                        state    <= S_APPLY;
                    end else begin
                        lat <= lat + LW'(1);
                    end
                end
                S_APPLY: begin
                    adv_q <= 1'b1;
                    state <= S_COUNT;
                    case (result_q)
                        2'b10: begin
                            if (pos_q < 6'd5) begin
                                pos_q <= pos_q + 6'd1;
                            end
                        end
                        2'b01: begin
                            if (pos_q != 6'd0) begin
                                pos_q <= pos_q - 6'd1;
                            end
                        end
                        2'b11: begin
                            hit_q   <= 1'b1;
                            lives_q <= lives_q - 2'd1;
                            if (lives_q == 2'd1) begin
                                over_q <= 1'b1;
                                state  <= S_OVER;
                            end
                        end
                        default: begin
                        end
                    endcase
`ifdef CAR_SCORE_EN
                    if (!((result_q == 2'b11) && (lives_q == 2'd1)) &&
                        (score_q != 16'hFFFF)) begin
                        score_q <= score_q + 16'd1;
                    end
`endif
                end
                S_OVER: begin
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.step        = step_q;
    assign bus.position    = pos_q;
    assign bus.lives       = lives_q;
    assign bus.hit         = hit_q;
    assign bus.row_advance = adv_q;
    assign bus.game_over   = over_q;
`ifdef CAR_SCORE_EN
    assign bus.score       = score_q;
`endif

endmodule
